hft_book_sequencer: RTL
=======================

// Module: hft_book_sequencer
// PURPOSE
//  Feeds the hft_zero_plus strategy core with top-of-book data and returns its decisions.
//  - Accepts top-of-book updates from the market-data parser and keeps the most recent one (latest-wins).
//  - Launches one core run per snapshot via ap_start/ap_ready/ap_done, holding all core inputs stable for the run.
//  - Tracks position and last fill from exchange fill reports.
//  - Publishes each core decision as a one-cycle tagged pulse to the order gateway.
// PARAMETERS
//  DATA_WIDTH      32    width of every price/qty/position/decision bus
//  STRONG_QTY      500   qty strictly above this sets the *_queue_strong input to 1
//  TIMEOUT_CYCLES  64    max cycles from launch to ap_done before the run is abandoned
// PORTS
//  ap_clk            in   1    clock
//  ap_rst            in   1    asynchronous reset, active-high
//  md_valid          in   1    top-of-book update present this cycle
//  md_ready          out  1    always 1; updates are never back-pressured
//  md_bid_price      in   DW   bid price, fixed-point cents
//  md_ask_price      in   DW   ask price, fixed-point cents
//  md_bid_qty        in   DW   bid quantity
//  md_ask_qty        in   DW   ask quantity
//  fill_valid        in   1    fill report present this cycle
//  fill_side         in   DW   1=BUY, 2=SELL; other values are ignored
//  fill_price        in   DW   fill price, cents
//  fill_qty          in   DW   fill quantity, unsigned
//  ap_start          out  1    core start
//  ap_ready          in   1    core has accepted its inputs
//  ap_done           in   1    core decision outputs are valid this cycle
//  ap_idle           in   1    core idle; status only
//  best_bid_price / best_ask_price / best_bid_qty / best_ask_qty  out  DW  snapshot to core
//  bid_queue_strong / ask_queue_strong     out  DW   0 or 1
//  current_position / last_fill_price / last_fill_side  out  DW  to core
//  action / price / quantity               in   DW   core decision outputs
//  dec_valid         out  1    one-cycle decision pulse
//  dec_action / dec_price / dec_qty        out  DW   captured on ap_done
//  dec_seq           out  16   sequence number of the snapshot that produced the decision
//  drop_count        out  16   number of updates overwritten before launch; saturating
//  err_timeout       out  1    sticky flag; cleared only by reset
// BEHAVIOUR
//  Reset values: every output is 0 except md_ready=1. State is IDLE and the pending slot is empty.
//  Pending slot (one entry):
//   - md_valid loads the slot and sets pend_full.
//   - md_valid while pend_full and not being launched: overwrite the slot; drop_count++ (saturates at 16'hFFFF).
//   - md_valid in the same cycle as a launch: the slot is reloaded; no drop is counted.
//  FSM:
//   IDLE   pend_full -> copy the slot to the best_* outputs, compute the strong flags, latch
//          current_position/last_fill_* into the core inputs, clear pend_full, seq++, go to ISSUE.
//   ISSUE  ap_start=1. On ap_ready: go to RUN; ap_start stays 1 through the ap_ready cycle, then drops.
//   RUN    ap_done -> capture action/price/quantity into dec_*; dec_valid=1 on the next cycle; go to IDLE.
//          If ap_done arrives in the same cycle as ap_ready, ISSUE goes directly to IDLE with the capture.
//  Timeout: a counter runs in ISSUE and RUN and starts at the launch cycle.
//   - Reaching TIMEOUT_CYCLES: set err_timeout, drop ap_start, go to IDLE, emit no dec_valid.
//  Snapshot outputs change only in the launch cycle, so they are constant from ap_start rise to ap_done.
//  Position:
//   - fill_valid with side 1: pos += qty. Side 2: pos -= qty. Signed, saturating at the DW signed min/max.
//   - Every valid fill also updates last_fill_price and last_fill_side.
//   - Core-facing copies refresh only at launch. A fill in the launch cycle is seen by the next run.
//  Latency: a md_valid received in IDLE with an empty slot puts ap_start high two cycles later.
//  Reset mid-run: everything returns to reset values immediately; no dec_valid is emitted.
//  dec_seq wraps 16'hFFFF -> 0.
// STRUCTURE
//  hft_pkg holds:
//   - typedef tob_t {bid_price, ask_price, bid_qty, ask_qty}
//   - enum seq_state_e {IDLE, ISSUE, RUN}
//   - constants ACT_HOLD=0, ACT_BUY=1, ACT_SELL=2
//  One sub-module: hft_position_tracker (fill -> saturating position and last fill).
// TESTING
//  1. Reset, then one update bid 10000/600 ask 10010/400.
//     -> ap_start at +2 cycles; bid_queue_strong=1, ask_queue_strong=0.
//     -> Core model returns action=1, price=10010, qty=100 -> dec_valid pulse with dec_seq=1.
//  2. Three updates during RUN.
//     -> drop_count=2; the next launch carries the third update's values.
//  3. Fills BUY 100 then SELL 250.
//     -> current_position=-150 at the next launch; last_fill_side=2.
//  4. Core never asserts ap_done.
//     -> err_timeout=1 after 64 cycles; no dec_valid; the next pending update still launches.
//  5. ap_rst asserted during RUN.
//     -> all outputs 0 the same cycle; no dec_valid after reset release.
//  6. Position at max positive, BUY 10 -> position holds at max.
//     md_valid in the launch cycle -> drop_count unchanged.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared types and constants for the book sequencer and its position tracker.
package hft_pkg;

    localparam int HFT_DW = 32;

    typedef struct packed {
        logic [HFT_DW-1:0] bid_price;
        logic [HFT_DW-1:0] ask_price;
        logic [HFT_DW-1:0] bid_qty;
        logic [HFT_DW-1:0] ask_qty;
    } tob_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        RUN   = ST_RUN
    } seq_state_e;

    localparam logic [HFT_DW-1:0] ACT_HOLD = 32'd0;
    localparam logic [HFT_DW-1:0] ACT_BUY  = 32'd1;
    localparam logic [HFT_DW-1:0] ACT_SELL = 32'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hft_position_tracker.sv
// Turns exchange fill reports into a signed, saturating position and remembers the last fill.
module hft_position_tracker
    import hft_pkg::*;
#(
    parameter int DATA_WIDTH = HFT_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_side,
    input  logic [DATA_WIDTH-1:0] fill_price,
    input  logic [DATA_WIDTH-1:0] fill_qty,
    output logic [DATA_WIDTH-1:0] position,
    output logic [DATA_WIDTH-1:0] last_fill_price,
    output logic [DATA_WIDTH-1:0] last_fill_side
);

    localparam logic [DATA_WIDTH-1:0] SIDE_BUY  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] SIDE_SELL = DATA_WIDTH'(2);
    // Two guard bits keep the unsigned qty and the signed position from overflowing the sum.
    localparam logic signed [DATA_WIDTH+1:0] POS_MAX = {2'b00, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH+1:0] POS_MIN = {2'b11, 1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] pos_q, pos_d;
    logic [DATA_WIDTH-1:0] lf_price_q, lf_price_d;
    logic [DATA_WIDTH-1:0] lf_side_q, lf_side_d;
    logic                  is_buy, is_sell;
    logic signed [DATA_WIDTH+1:0] pos_ext, qty_ext, sum;

    // Next-state for position and last-fill registers.
    always_comb begin
        is_buy  = fill_valid && (fill_side == SIDE_BUY);
        is_sell = fill_valid && (fill_side == SIDE_SELL);
        pos_ext = {{2{pos_q[DATA_WIDTH-1]}}, pos_q};
        qty_ext = {2'b00, fill_qty};
        if (is_sell) begin
            sum = pos_ext - qty_ext;
        end else begin
            sum = pos_ext + qty_ext;
        end
        pos_d      = pos_q;
        lf_price_d = lf_price_q;
        lf_side_d  = lf_side_q;
        if (is_buy || is_sell) begin
            lf_price_d = fill_price;
            lf_side_d  = fill_side;
            if (sum > POS_MAX) begin
                pos_d = POS_MAX[DATA_WIDTH-1:0];
            end else if (sum < POS_MIN) begin
                pos_d = POS_MIN[DATA_WIDTH-1:0];
            end else begin
                pos_d = sum[DATA_WIDTH-1:0];
            end
        end else begin
            pos_d = pos_q;
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q      <= '0;
            lf_price_q <= '0;
            lf_side_q  <= '0;
        end else begin
            pos_q      <= pos_d;
            lf_price_q <= lf_price_d;
            lf_side_q  <= lf_side_d;
        end
    end

    assign position        = pos_q;
    assign last_fill_price = lf_price_q;
    assign last_fill_side  = lf_side_q;

endmodule

// File: rtl/hft_book_sequencer.sv
// Latest-wins top-of-book buffer that launches one strategy-core run per snapshot and
// republishes each decision as a tagged one-cycle pulse.
module hft_book_sequencer
    import hft_pkg::*;
#(
    parameter int DATA_WIDTH     = HFT_DW,
    parameter int STRONG_QTY     = 500,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  md_valid,
    output logic                  md_ready,
    input  logic [DATA_WIDTH-1:0] md_bid_price,
    input  logic [DATA_WIDTH-1:0] md_ask_price,
    input  logic [DATA_WIDTH-1:0] md_bid_qty,
    input  logic [DATA_WIDTH-1:0] md_ask_qty,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_side,
    input  logic [DATA_WIDTH-1:0] fill_price,
    input  logic [DATA_WIDTH-1:0] fill_qty,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    input  logic                  ap_idle,
    output logic [DATA_WIDTH-1:0] best_bid_price,
    output logic [DATA_WIDTH-1:0] best_ask_price,
    output logic [DATA_WIDTH-1:0] best_bid_qty,
    output logic [DATA_WIDTH-1:0] best_ask_qty,
    output logic [DATA_WIDTH-1:0] bid_queue_strong,
    output logic [DATA_WIDTH-1:0] ask_queue_strong,
    output logic [DATA_WIDTH-1:0] current_position,
    output logic [DATA_WIDTH-1:0] last_fill_price,
    output logic [DATA_WIDTH-1:0] last_fill_side,
    input  logic [DATA_WIDTH-1:0] action,
    input  logic [DATA_WIDTH-1:0] price,
    input  logic [DATA_WIDTH-1:0] quantity,
    output logic                  dec_valid,
    output logic [DATA_WIDTH-1:0] dec_action,
    output logic [DATA_WIDTH-1:0] dec_price,
    output logic [DATA_WIDTH-1:0] dec_qty,
    output logic [15:0]           dec_seq,
    output logic [15:0]           drop_count,
    output logic                  err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]         TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] STRONG_THR = DATA_WIDTH'(STRONG_QTY);
    localparam logic [DATA_WIDTH-1:0] FLAG_ONE   = DATA_WIDTH'(1);

    seq_state_e            state_q, state_d;
    tob_t                  slot_q, slot_d, best_q, best_d;
    logic                  pend_full_q, pend_full_d;
    logic                  ap_start_q, ap_start_d;
    logic [DATA_WIDTH-1:0] bid_strong_q, bid_strong_d, ask_strong_q, ask_strong_d;
    logic [DATA_WIDTH-1:0] cur_pos_q, cur_pos_d, lf_price_q, lf_price_d, lf_side_q, lf_side_d;
    logic [15:0]           seq_q, seq_d, drop_q, drop_d, dec_seq_q, dec_seq_d;
    logic                  dec_valid_q, dec_valid_d;
    logic [DATA_WIDTH-1:0] dec_action_q, dec_action_d, dec_price_q, dec_price_d, dec_qty_q, dec_qty_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  launch, take_dec;
    logic [DATA_WIDTH-1:0] trk_pos, trk_lf_price, trk_lf_side;
    logic                  unused_ok;

    assign unused_ok = ap_idle;

    hft_position_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_pos (
        .clk             (ap_clk),
        .rst             (ap_rst),
        .fill_valid      (fill_valid),
        .fill_side       (fill_side),
        .fill_price      (fill_price),
        .fill_qty        (fill_qty),
        .position        (trk_pos),
        .last_fill_price (trk_lf_price),
        .last_fill_side  (trk_lf_side)
    );

    assign launch = (state_q == IDLE) && pend_full_q;

    // Pending slot, launch sequencing, timeout and decision capture.
    always_comb begin
        slot_d       = slot_q;
        pend_full_d  = pend_full_q;
        drop_d       = drop_q;
        state_d      = state_q;
        ap_start_d   = ap_start_q;
        best_d       = best_q;
        bid_strong_d = bid_strong_q;
        ask_strong_d = ask_strong_q;
        cur_pos_d    = cur_pos_q;
        lf_price_d   = lf_price_q;
        lf_side_d    = lf_side_q;
        seq_d        = seq_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        take_dec     = 1'b0;
        dec_valid_d  = 1'b0;
        dec_action_d = dec_action_q;
        dec_price_d  = dec_price_q;
        dec_qty_d    = dec_qty_q;
        dec_seq_d    = dec_seq_q;

        // A launch empties the slot in the same edge, so a coincident update is a reload, not a drop.
        if (md_valid) begin
            slot_d      = '{bid_price: md_bid_price, ask_price: md_ask_price,
                            bid_qty: md_bid_qty, ask_qty: md_ask_qty};
            pend_full_d = 1'b1;
            if (pend_full_q && !launch) begin
                drop_d = sat_inc16(drop_q);
            end else begin
                drop_d = drop_q;
            end
        end else if (launch) begin
            pend_full_d = 1'b0;
        end else begin
            pend_full_d = pend_full_q;
        end

        case (state_q)
            IDLE: begin
                if (pend_full_q) begin
                    best_d       = slot_q;
                    bid_strong_d = (slot_q.bid_qty > STRONG_THR) ? FLAG_ONE : '0;
                    ask_strong_d = (slot_q.ask_qty > STRONG_THR) ? FLAG_ONE : '0;
                    cur_pos_d    = trk_pos;
                    lf_price_d   = trk_lf_price;
                    lf_side_d    = trk_lf_side;
                    seq_d        = seq_q + 16'd1;
                    tmo_d        = '0;
                    ap_start_d   = 1'b1;
                    state_d      = ISSUE;
                end else begin
                    ap_start_d = 1'b0;
                end
            end
            ISSUE: begin
                if (ap_ready && ap_done) begin
                    take_dec   = 1'b1;
                    ap_start_d = 1'b0;
                    state_d    = IDLE;
                end else if (ap_ready) begin
                    ap_start_d = 1'b0;
                    tmo_d      = tmo_q + TW'(1);
                    state_d    = RUN;
                end else if (tmo_q >= TMO_LAST) begin
                    err_d      = 1'b1;
                    ap_start_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RUN: begin
                if (ap_done) begin
                    take_dec = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_q >= TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                ap_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

        if (take_dec) begin
            dec_valid_d  = 1'b1;
            dec_action_d = action;
            dec_price_d  = price;
            dec_qty_d    = quantity;
            dec_seq_d    = seq_q;
        end else begin
            dec_valid_d = 1'b0;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            pend_full_q  <= 1'b0;
            drop_q       <= '0;
            ap_start_q   <= 1'b0;
            best_q       <= '0;
            bid_strong_q <= '0;
            ask_strong_q <= '0;
            cur_pos_q    <= '0;
            lf_price_q   <= '0;
            lf_side_q    <= '0;
            seq_q        <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            dec_valid_q  <= 1'b0;
            dec_action_q <= '0;
            dec_price_q  <= '0;
            dec_qty_q    <= '0;
            dec_seq_q    <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            pend_full_q  <= pend_full_d;
            drop_q       <= drop_d;
            ap_start_q   <= ap_start_d;
            best_q       <= best_d;
            bid_strong_q <= bid_strong_d;
            ask_strong_q <= ask_strong_d;
            cur_pos_q    <= cur_pos_d;
            lf_price_q   <= lf_price_d;
            lf_side_q    <= lf_side_d;
            seq_q        <= seq_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            dec_valid_q  <= dec_valid_d;
            dec_action_q <= dec_action_d;
            dec_price_q  <= dec_price_d;
            dec_qty_q    <= dec_qty_d;
            dec_seq_q    <= dec_seq_d;
        end
    end

    assign md_ready         = 1'b1;
    assign ap_start         = ap_start_q;
    assign best_bid_price   = best_q.bid_price;
    assign best_ask_price   = best_q.ask_price;
    assign best_bid_qty     = best_q.bid_qty;
    assign best_ask_qty     = best_q.ask_qty;
    assign bid_queue_strong = bid_strong_q;
    assign ask_queue_strong = ask_strong_q;
    assign current_position = cur_pos_q;
    assign last_fill_price  = lf_price_q;
    assign last_fill_side   = lf_side_q;
    assign dec_valid        = dec_valid_q;
    assign dec_action       = dec_action_q;
    assign dec_price        = dec_price_q;
    assign dec_qty          = dec_qty_q;
    assign dec_seq          = dec_seq_q;
    assign drop_count       = drop_q;
    assign err_timeout      = err_q;

endmodule
